jtag_uart_sys_memory_arbiter: RTL and testbench

Two-master arbiter sharing the single-port 2048×32 on-chip memory (byte-enabled, 1-cycle read latency) between the Nios II data master and a user-hardware master. Sits directly in front of the memory's slave port. Arbitration is round-robin with a bounded hold counter. Each master sees an Avalon-MM pipelined interface with waitrequest and readdatavalid.

---
 rtl/jtag_uart_sys_memory_arbiter_pkg.sv | 18 +
 rtl/jtag_uart_sys_memory_arbiter_mem_arb_rr_grant.sv | 30 +++
 rtl/jtag_uart_sys_memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_jtag_uart_sys_memory_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_uart_sys_memory_arbiter_pkg.sv
// Shared widths, defaults and master index type for the JTAG UART system memory arbiter.
package jtag_uart_sys_memory_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W           = 11;
    localparam int unsigned MEM_DATA_W           = 32;
    localparam int unsigned MEM_ARB_HOLD_DEFAULT = 4;
    localparam int unsigned HOLD_CNT_W           = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    function automatic master_e other_master(input master_e m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/jtag_uart_sys_memory_arbiter_mem_arb_rr_grant.sv
// Combinational two-way round-robin grant; the last winner may keep the port for up to HOLD contended cycles.
module mem_arb_rr_grant
    import jtag_uart_sys_memory_arbiter_pkg::*;
#(
    parameter int unsigned HOLD = MEM_ARB_HOLD_DEFAULT
) (
    input  logic [1:0]            req,
    input  master_e               last_grant,
    input  logic [HOLD_CNT_W-1:0] hold_cnt,
    output logic [1:0]            gnt
);

    logic    incumbent_holds;
    master_e winner;

    always_comb begin
        // A zero count means the previous cycle was uncontended, so fresh contention opens
        // with a switch away from last_grant; this is what gives m0 the first contention after reset.
        incumbent_holds = (hold_cnt != '0) && (hold_cnt < HOLD_CNT_W'(HOLD)) && req[last_grant];
        winner          = incumbent_holds ? last_grant : other_master(last_grant);
        gnt             = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt[winner] = 1'b1;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/jtag_uart_sys_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port on-chip memory.
// Defining MEM_ARB_PERF_EN adds grant and conflict performance counters.
module jtag_uart_sys_memory_arbiter
    import jtag_uart_sys_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned HOLD   = MEM_ARB_HOLD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]         m0_grant_cnt,
    output logic [31:0]         m1_grant_cnt,
    output logic [31:0]         conflict_cnt,
`endif
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [1:0]            req;
    logic [1:0]            wr_req;
    logic [1:0]            gnt_raw;
    logic [1:0]            gnt;
    master_e               winner;

    master_e               last_grant_q, last_grant_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]            rd_pend_q, rd_pend_d;

    always_comb begin
        req    = {m1_read | m1_write, m0_read | m0_write};
        wr_req = {m1_write, m0_write};
    end

    mem_arb_rr_grant #(
        .HOLD(HOLD)
    ) u_rr_grant (
        .req        (req),
        .last_grant (last_grant_q),
        .hold_cnt   (hold_cnt_q),
        .gnt        (gnt_raw)
    );

    // Reset blocks every grant so both masters stall and the memory is deselected.
    always_comb begin
        gnt            = reset ? 2'b00 : gnt_raw;
        winner         = gnt[1] ? M1 : M0;
        m0_waitrequest = reset | (req[0] & ~gnt[0]);
        m1_waitrequest = reset | (req[1] & ~gnt[1]);
        mem_address    = gnt[1] ? m1_address    : m0_address;
        mem_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
        mem_writedata  = gnt[1] ? m1_writedata  : m0_writedata;
        mem_chipselect = |gnt;
        mem_write      = |(gnt & wr_req);
        mem_clken      = 1'b1;
    end

    always_comb begin
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = rd_pend_q[0];
        m1_readdatavalid = rd_pend_q[1];
    end

    always_comb begin
        last_grant_d = (|gnt) ? winner : last_grant_q;
        hold_cnt_d   = '0;
        if (&req) begin
            if (winner == last_grant_q) begin
                hold_cnt_d = (hold_cnt_q >= HOLD_CNT_W'(HOLD)) ? HOLD_CNT_W'(HOLD)
                                                               : hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_d = HOLD_CNT_W'(1);
            end
        end
        // A read+write pair is issued as a write, so it produces no read response.
        rd_pend_d = gnt & ~wr_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= M1;
            hold_cnt_q   <= '0;
            rd_pend_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] m0_grant_cnt_q, m0_grant_cnt_d;
    logic [31:0] m1_grant_cnt_q, m1_grant_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        m0_grant_cnt_d = m0_grant_cnt_q + 32'(gnt[0]);
        m1_grant_cnt_d = m1_grant_cnt_q + 32'(gnt[1]);
        conflict_cnt_d = conflict_cnt_q + 32'(&req);
        m0_grant_cnt   = m0_grant_cnt_q;
        m1_grant_cnt   = m1_grant_cnt_q;
        conflict_cnt   = conflict_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_grant_cnt_q <= '0;
            m1_grant_cnt_q <= '0;
            conflict_cnt_q <= '0;
        end else begin
            m0_grant_cnt_q <= m0_grant_cnt_d;
            m1_grant_cnt_q <= m1_grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_jtag_uart_sys_memory_arbiter.sv
// Self-checking bench for jtag_uart_sys_memory_arbiter against a transaction-level arbitration/memory model.
`timescale 1ns/1ps
module tb_jtag_uart_sys_memory_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_clear;
    logic [10:0] m_addr [2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic [3:0]  m_be   [2];
    logic [31:0] m_wd   [2];
    logic        m_wait [2];
    logic [31:0] m_rdata[2];
    logic        m_rdv  [2];
    logic [10:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_chipselect, mem_write, mem_clken;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] m0_grant_cnt, m1_grant_cnt, conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtag_uart_sys_memory_arbiter #(
        .ADDR_W(11),
        .DATA_W(32),
        .HOLD  (HOLD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m_addr[0]),
        .m0_read          (m_rd[0]),
        .m0_write         (m_wr[0]),
        .m0_byteenable    (m_be[0]),
        .m0_writedata     (m_wd[0]),
        .m0_waitrequest   (m_wait[0]),
        .m0_readdata      (m_rdata[0]),
        .m0_readdatavalid (m_rdv[0]),
        .m1_address       (m_addr[1]),
        .m1_read          (m_rd[1]),
        .m1_write         (m_wr[1]),
        .m1_byteenable    (m_be[1]),
        .m1_writedata     (m_wd[1]),
        .m1_waitrequest   (m_wait[1]),
        .m1_readdata      (m_rdata[1]),
        .m1_readdatavalid (m_rdv[1]),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
`ifdef MEM_ARB_PERF_EN
        .m0_grant_cnt     (m0_grant_cnt),
        .m1_grant_cnt     (m1_grant_cnt),
        .conflict_cnt     (conflict_cnt),
`endif
        .mem_readdata     (mem_readdata)
    );

    // Memory device behind the arbiter: byte-enabled writes, one-cycle registered reads.
    logic [31:0] ram [2048];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 2048; i++) ram[i] <= '0;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model: which master owns the port, how long it has held it under contention,
    // the storage contents and the read responses due next cycle.
    int          mdl_last;
    int          mdl_streak;
    bit          mdl_pend [2];
    logic [31:0] mdl_rdata[2];
    logic [31:0] mdl_mem  [2048];

    function automatic bit wants(input int m);
        return m_rd[m] | m_wr[m];
    endfunction

    function automatic int mdl_winner();
        if (!wants(0) && !wants(1)) return -1;
        if (!wants(1)) return 0;
        if (!wants(0)) return 1;
        if (mdl_streak > 0 && mdl_streak < HOLD) return mdl_last;
        return 1 - mdl_last;
    endfunction

    task automatic mdl_reset();
        mdl_last    = 1;
        mdl_streak  = 0;
        mdl_pend[0] = 0;
        mdl_pend[1] = 0;
    endtask

    task automatic tick(input int w);
        @(posedge clk);
        if (wants(0) && wants(1))
            mdl_streak = (w == mdl_last) ? ((mdl_streak >= HOLD) ? HOLD : mdl_streak + 1) : 1;
        else
            mdl_streak = 0;
        mdl_pend[0] = 0;
        mdl_pend[1] = 0;
        if (w >= 0) begin
            mdl_last = w;
            if (m_wr[w]) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[w][b]) mdl_mem[m_addr[w]][8*b +: 8] = m_wd[w][8*b +: 8];
            end else begin
                mdl_pend[w]  = 1;
                mdl_rdata[w] = mdl_mem[m_addr[w]];
            end
        end
        @(negedge clk);
    endtask

    task automatic set_m(input int m, input logic rd, input logic wr, input logic [10:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        m_rd[m]   = rd;
        m_wr[m]   = wr;
        m_addr[m] = a;
        m_be[m]   = be;
        m_wd[m]   = wd;
    endtask

    task automatic idle();
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mdl_reset();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ram_clear = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        set_m(0, 1, 0, 11'h001, 4'hF, '0);
        set_m(1, 0, 1, 11'h002, 4'hF, 32'h1234_5678);
        #1;
        checks++; if (m_wait[0] !== 1'b1) begin errors++; $display("FAIL reset_wait0 got %b want 1", m_wait[0]); end
        checks++; if (m_wait[1] !== 1'b1) begin errors++; $display("FAIL reset_wait1 got %b want 1", m_wait[1]); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", mem_chipselect); end
        checks++; if (m_rdv[0] !== 1'b0 || m_rdv[1] !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b%b want 00", m_rdv[1], m_rdv[0]); end
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL reset_clken got %b want 1", mem_clken); end
        @(negedge clk);
        idle();
        reset     = 1'b0;
        ram_clear = 1'b0;
        mdl_reset();
        #1;
        checks++; if (m_wait[0] !== 1'b0 || m_wait[1] !== 1'b0) begin errors++; $display("FAIL idle_wait got %b%b want 00", m_wait[1], m_wait[0]); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL idle_cs got %b want 0", mem_chipselect); end
    endtask

    task automatic test_lone_write_read();
        set_m(0, 0, 1, 11'h005, 4'hF, 32'hDEAD_BEEF);
        #1;
        checks++; if (m_wait[0] !== 1'b0) begin errors++; $display("FAIL lone_wr_wait got %b want 0", m_wait[0]); end
        checks++; if (mem_write !== 1'b1 || mem_address !== 11'h005) begin errors++; $display("FAIL lone_wr_mem got we=%b addr=%h want we=1 addr=005", mem_write, mem_address); end
        tick(mdl_winner());
        set_m(0, 1, 0, 11'h005, 4'hF, '0);
        #1;
        checks++; if (m_wait[0] !== 1'b0) begin errors++; $display("FAIL lone_rd_wait got %b want 0", m_wait[0]); end
        checks++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b1) begin errors++; $display("FAIL lone_rd_mem got we=%b cs=%b want we=0 cs=1", mem_write, mem_chipselect); end
        tick(mdl_winner());
        idle();
        #1;
        checks++; if (m_rdv[0] !== 1'b1 || m_rdv[1] !== 1'b0) begin errors++; $display("FAIL lone_rdv got %b%b want 01", m_rdv[1], m_rdv[0]); end
        checks++; if (m_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lone_rdata got %h want deadbeef", m_rdata[0]); end
        tick(mdl_winner());
        #1;
        checks++; if (m_rdv[0] !== 1'b0) begin errors++; $display("FAIL lone_rdv_drop got %b want 0", m_rdv[0]); end
    endtask

    task automatic test_byte_lanes();
        set_m(1, 0, 1, 11'h7FF, 4'hF, 32'h1122_3344);
        #1;
        checks++; if (m_wait[1] !== 1'b0) begin errors++; $display("FAIL lanes_wr1_wait got %b want 0", m_wait[1]); end
        tick(mdl_winner());
        set_m(1, 0, 1, 11'h7FF, 4'h2, 32'h0000_AA00);
        #1;
        checks++; if (mem_byteenable !== 4'h2 || mem_writedata !== 32'h0000_AA00) begin errors++; $display("FAIL lanes_wr2_mem got be=%h wd=%h want be=2 wd=0000aa00", mem_byteenable, mem_writedata); end
        tick(mdl_winner());
        set_m(1, 1, 0, 11'h7FF, 4'hF, '0);
        #1;
        tick(mdl_winner());
        idle();
        #1;
        checks++; if (m_rdv[1] !== 1'b1 || m_rdata[1] !== 32'h1122_AA44) begin errors++; $display("FAIL lanes_read got rdv=%b data=%h want rdv=1 data=1122aa44", m_rdv[1], m_rdata[1]); end
        tick(mdl_winner());
    endtask

    task automatic test_first_contention();
        int  waited;
        bit  granted;
        apply_reset();
        set_m(0, 1, 0, 11'h003, 4'hF, '0);
        set_m(1, 1, 0, 11'h004, 4'hF, '0);
        #1;
        checks++; if (m_wait[0] !== 1'b0 || m_wait[1] !== 1'b1) begin errors++; $display("FAIL first_contention got wait1,wait0=%b%b want 10", m_wait[1], m_wait[0]); end
        waited  = 0;
        granted = 0;
        for (int c = 0; c < 3 * HOLD; c++) begin
            if (m_wait[1] === 1'b0) begin
                granted = 1;
                break;
            end
            waited++;
            tick(mdl_winner());
            #1;
        end
        checks++; if (!granted || waited < 1 || waited > HOLD) begin errors++; $display("FAIL m1_wait_bound got granted=%0d waited=%0d want granted=1 waited 1..%0d", granted, waited, HOLD); end
        tick(mdl_winner());
        idle();
        tick(mdl_winner());
    endtask

    task automatic test_random();
        int w;
        int r;
        for (int i = 0; i < 300; i++) begin
            for (int m = 0; m < 2; m++) begin
                r = $urandom_range(0, 9);
                set_m(m, (r >= 3 && r <= 6) || r == 9, r >= 7,
                      ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)),
                      4'($urandom), $urandom);
            end
            #1;
            w = mdl_winner();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (m_wait[m] !== (wants(m) && w != m)) begin errors++; $display("FAIL rnd_wait%0d cyc %0d got %b want %b", m, i, m_wait[m], wants(m) && w != m); end
            end
            checks++; if (mem_chipselect !== (w >= 0)) begin errors++; $display("FAIL rnd_cs cyc %0d got %b want %b", i, mem_chipselect, w >= 0); end
            if (w >= 0) begin
                checks++;
                if (mem_address !== m_addr[w] || mem_write !== m_wr[w] || mem_byteenable !== m_be[w]) begin
                    errors++;
                    $display("FAIL rnd_mem cyc %0d got a=%h we=%b be=%h want a=%h we=%b be=%h", i, mem_address, mem_write, mem_byteenable, m_addr[w], m_wr[w], m_be[w]);
                end
                if (m_wr[w]) begin
                    checks++; if (mem_writedata !== m_wd[w]) begin errors++; $display("FAIL rnd_wdata cyc %0d got %h want %h", i, mem_writedata, m_wd[w]); end
                end
            end
            tick(w);
            for (int m = 0; m < 2; m++) begin
                checks++; if (m_rdv[m] !== mdl_pend[m]) begin errors++; $display("FAIL rnd_rdv%0d cyc %0d got %b want %b", m, i, m_rdv[m], mdl_pend[m]); end
                if (mdl_pend[m]) begin
                    checks++; if (m_rdata[m] !== mdl_rdata[m]) begin errors++; $display("FAIL rnd_rdata%0d cyc %0d got %h want %h", m, i, m_rdata[m], mdl_rdata[m]); end
                end
            end
        end
        idle();
        tick(mdl_winner());
    endtask

    task automatic test_back_to_back_contention();
        int w;
        int g;
        int prev;
        int run;
        int gh [40];
        bit s0, s1;
        prev = -1;
        run  = 0;
        for (int i = 0; i < 40; i++) begin
            set_m(0, 1, 0, 11'($urandom_range(0, 15)), 4'hF, '0);
            set_m(1, 1, 0, ($urandom_range(0, 3) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)), 4'hF, '0);
            #1;
            w = mdl_winner();
            g = (m_wait[0] === 1'b0) ? 0 : ((m_wait[1] === 1'b0) ? 1 : -1);
            gh[i] = g;
            checks++; if (g != w || m_wait[0] === m_wait[1]) begin errors++; $display("FAIL b2b_grant cyc %0d got wait1,wait0=%b%b want winner m%0d", i, m_wait[1], m_wait[0], w); end
            run = (g == prev) ? run + 1 : 1;
            prev = g;
            checks++; if (run > HOLD) begin errors++; $display("FAIL b2b_hold cyc %0d got run %0d want <= %0d", i, run, HOLD); end
            tick(w);
            checks++; if (m_rdv[0] === 1'b1 && m_rdv[1] === 1'b1) begin errors++; $display("FAIL b2b_dual_rdv cyc %0d got 11 want one-hot", i); end
            for (int m = 0; m < 2; m++) begin
                checks++; if (m_rdv[m] !== mdl_pend[m]) begin errors++; $display("FAIL b2b_rdv%0d cyc %0d got %b want %b", m, i, m_rdv[m], mdl_pend[m]); end
                if (mdl_pend[m]) begin
                    checks++; if (m_rdata[m] !== mdl_rdata[m]) begin errors++; $display("FAIL b2b_rdata%0d cyc %0d got %h want %h", m, i, m_rdata[m], mdl_rdata[m]); end
                end
            end
        end
        for (int i = 0; i + 5 <= 40; i++) begin
            s0 = 0;
            s1 = 0;
            for (int k = i; k < i + 5; k++) begin
                if (gh[k] == 0) s0 = 1;
                if (gh[k] == 1) s1 = 1;
            end
            checks++; if (!(s0 && s1)) begin errors++; $display("FAIL b2b_window at %0d got m0=%0d m1=%0d want both", i, s0, s1); end
        end
        idle();
        tick(mdl_winner());
    endtask

    task automatic test_reset_mid_read();
        idle();
        set_m(1, 1, 0, 11'h7FF, 4'hF, '0);
        #1;
        checks++; if (m_wait[1] !== 1'b0) begin errors++; $display("FAIL midrst_accept got %b want 0", m_wait[1]); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        #1;
        checks++; if (m_rdv[1] !== 1'b0) begin errors++; $display("FAIL midrst_rdv_drop got %b want 0", m_rdv[1]); end
        set_m(0, 1, 0, 11'h001, 4'hF, '0);
        set_m(1, 1, 0, 11'h002, 4'hF, '0);
        #1;
        checks++; if (m_wait[0] !== 1'b1 || m_wait[1] !== 1'b1 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL midrst_stall got wait=%b%b cs=%b want 11 cs=0", m_wait[1], m_wait[0], mem_chipselect); end
        @(negedge clk);
        @(negedge clk);
        idle();
        reset = 1'b0;
        mdl_reset();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (m_rdv[0] !== 1'b0 || m_rdv[1] !== 1'b0) begin errors++; $display("FAIL midrst_late_rdv cyc %0d got %b%b want 00", c, m_rdv[1], m_rdv[0]); end
            tick(mdl_winner());
        end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf_counters();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            set_m(0, 1, 0, 11'($urandom_range(0, 15)), 4'hF, '0);
            set_m(1, 1, 0, 11'($urandom_range(0, 15)), 4'hF, '0);
            #1;
            tick(mdl_winner());
        end
        idle();
        #1;
        checks++; if (conflict_cnt !== 32'd10) begin errors++; $display("FAIL perf_conflict got %0d want 10", conflict_cnt); end
        checks++; if (m0_grant_cnt + m1_grant_cnt !== 32'd10) begin errors++; $display("FAIL perf_grants got %0d want 10", m0_grant_cnt + m1_grant_cnt); end
        tick(mdl_winner());
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mdl_mem[i] = '0;
        mdl_reset();
        test_reset();
        test_lone_write_read();
        test_byte_lanes();
        test_first_contention();
        test_random();
        test_back_to_back_contention();
        test_reset_mid_read();
`ifdef MEM_ARB_PERF_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
